// File: rtl/ldpc_frame_feeder_if.sv
// LLR input stream from the demapper into the LDPC frame feeder.
// master = demapper side, slave = feeder side.
interface ldpc_frame_feeder_if #(
    parameter int D_WID = 6
);
    logic [D_WID-1:0] in_data;
    logic             in_valid;
    logic             in_sof;
    logic             in_rate;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_sof,
        output in_rate,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sof,
        input  in_rate,
        output in_ready
    );
endinterface

// File: rtl/ldpc_frame_feeder.sv
// Ping-pong frame buffer that collects soft LLRs and replays each
// complete codeword to the LDPC decoder as one gap-free sync burst.
module ldpc_frame_feeder #(
    parameter int D_WID    = 6,
    parameter int DATA_DEP = 9216,
    parameter int A_WID    = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    ldpc_frame_feeder_if.slave   in_if,
    input  logic [4:0]           cfg_max_iter,
    input  logic                 dec_busy,
    output logic [D_WID-1:0]     dec_data,
    output logic                 dec_sync,
    output logic                 dec_code_rate,
    output logic [4:0]           dec_max_iter,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [A_WID-1:0] LAST  = A_WID'(DATA_DEP - 1);
    localparam logic [A_WID-1:0] A_ONE = A_WID'(1);

    logic [D_WID-1:0] mem0 [DATA_DEP];
    logic [D_WID-1:0] mem1 [DATA_DEP];

    logic [1:0]       full;
    logic [1:0]       rate_flag;
    logic             wr_bank;
    logic             rd_bank;
    logic             synced;
    logic [A_WID-1:0] wr_addr;
    logic [A_WID-1:0] waddr;
    logic [A_WID-1:0] rd_addr;
    logic [A_WID-1:0] rd_raddr;
    logic [1:0]       state;
    logic             accept;
    logic             we;
    logic             wr_last;
    logic             rd_last;
    logic             launch;
    logic [D_WID-1:0] rd_word;

    assign in_if.in_ready = ~reset & ~full[wr_bank];

    assign accept  = in_if.in_valid & in_if.in_ready;
    assign we      = accept & (in_if.in_sof | synced);
    assign waddr   = in_if.in_sof ? '0 : wr_addr;
    assign wr_last = we & (waddr == LAST);

    assign rd_last  = (state == S_SEND) & (rd_addr == LAST);
    assign launch   = full[rd_bank] & ~dec_busy;
    assign rd_raddr = (state == S_SEND && !rd_last) ? rd_addr + A_ONE : '0;
    assign rd_word  = rd_bank ? mem1[rd_raddr] : mem0[rd_raddr];

    always_ff @(posedge clk) begin
        if (we && !wr_bank) mem0[waddr] <= in_if.in_data;
        if (we && wr_bank)  mem1[waddr] <= in_if.in_data;
    end

    // Full flags are shared: the writer sets its bank, the reader clears its own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full      <= '0;
            rate_flag <= '0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            synced    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & in_if.in_sof & (wr_addr != '0);
            if (accept && in_if.in_sof) begin
                synced             <= 1'b1;
                rate_flag[wr_bank] <= in_if.in_rate;
            end
            if (we) begin
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_addr       <= '0;
                end else begin
                    wr_addr <= waddr + A_ONE;
                end
            end
            if (rd_last) full[rd_bank] <= 1'b0;
        end
    end

    // GAP doubles as the fetch slot so back-to-back bursts keep a single low cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            rd_bank       <= 1'b0;
            rd_addr       <= '0;
            dec_data      <= '0;
            dec_sync      <= 1'b0;
            dec_code_rate <= 1'b0;
            dec_max_iter  <= '0;
            frame_cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        state         <= S_FETCH;
                        dec_code_rate <= rate_flag[rd_bank];
                        dec_max_iter  <= cfg_max_iter;
                    end
                end
                S_FETCH: begin
                    state    <= S_SEND;
                    dec_sync <= 1'b1;
                    dec_data <= rd_word;
                    rd_addr  <= '0;
                end
                S_SEND: begin
                    if (rd_last) begin
                        state     <= S_GAP;
                        dec_sync  <= 1'b0;
                        dec_data  <= '0;
                        rd_bank   <= ~rd_bank;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        dec_data <= rd_word;
                        rd_addr  <= rd_addr + A_ONE;
                    end
                end
                S_GAP: begin
                    if (launch) begin
                        state         <= S_SEND;
                        dec_sync      <= 1'b1;
                        dec_data      <= rd_word;
                        rd_addr       <= '0;
                        dec_code_rate <= rate_flag[rd_bank];
                        dec_max_iter  <= cfg_max_iter;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_frame_feeder.sv
// Randomised bench for ldpc_frame_feeder with a frame-level reference
// model built from accepted input words.
module tb_ldpc_frame_feeder;
    localparam int DW  = 6;
    localparam int DEP = 16;
    typedef logic [DW-1:0] frame_t [DEP];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    cfg_max_iter = '0;
    logic          dec_busy = 1'b0;
    logic [DW-1:0] dec_data;
    logic          dec_sync;
    logic          dec_code_rate;
    logic [4:0]    dec_max_iter;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    ldpc_frame_feeder_if #(.D_WID(DW)) in_if ();

    ldpc_frame_feeder #(.D_WID(DW), .DATA_DEP(DEP), .A_WID(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_if(in_if),
        .cfg_max_iter(cfg_max_iter),
        .dec_busy(dec_busy),
        .dec_data(dec_data),
        .dec_sync(dec_sync),
        .dec_code_rate(dec_code_rate),
        .dec_max_iter(dec_max_iter),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // observed bursts
    int            cyc = 0;
    bit            in_burst = 0;
    int            cur_len = 0;
    int            b_start[$], b_end[$], b_len[$], b_off[$];
    logic          b_rate[$];
    logic [4:0]    b_iter[$];
    logic [DW-1:0] words[$];
    int            data_low = 0, unstable = 0, err_cnt = 0, last_acc = 0;
    // reference model: complete frames expected at the decoder
    bit            m_synced = 0;
    logic          m_rate = 0;
    logic [DW-1:0] m_cur[$];
    logic [DW-1:0] exp_words[$];
    logic          exp_rate[$];
    int            exp_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_synced = 0;
            m_cur.delete();
        end
        if (dec_sync) begin
            if (!in_burst) begin
                in_burst = 1;
                cur_len = 0;
                b_start.push_back(cyc);
                b_off.push_back(words.size());
                b_rate.push_back(dec_code_rate);
                b_iter.push_back(dec_max_iter);
            end else if (dec_code_rate !== b_rate[$] || dec_max_iter !== b_iter[$]) begin
                unstable++;
            end
            words.push_back(dec_data);
            cur_len++;
        end else begin
            if (in_burst) begin
                in_burst = 0;
                b_len.push_back(cur_len);
                b_end.push_back(cyc);
            end
            if (dec_data !== '0) data_low++;
        end
        if (frame_err) err_cnt++;
        if (!reset && in_if.in_valid && in_if.in_ready) begin
            last_acc = cyc;
            if (in_if.in_sof) begin
                if (m_cur.size() > 0) exp_err++;
                m_cur.delete();
                m_synced = 1;
                m_rate = in_if.in_rate;
            end
            if (m_synced) begin
                m_cur.push_back(in_if.in_data);
                if (m_cur.size() == DEP) begin
                    foreach (m_cur[k]) exp_words.push_back(m_cur[k]);
                    exp_rate.push_back(m_rate);
                    m_cur.delete();
                end
            end
        end
    end

    task automatic clear_mon;
        b_start.delete(); b_end.delete(); b_len.delete(); b_off.delete();
        b_rate.delete(); b_iter.delete(); words.delete();
        exp_words.delete(); exp_rate.delete();
        data_low = 0; unstable = 0; err_cnt = 0; exp_err = 0;
    endtask

    function automatic int burst_diff(input int i, input int j);
        int d = 0;
        if (i >= b_len.size() || (j + 1) * DEP > exp_words.size()) return 100;
        if (b_len[i] != DEP) return 100;
        for (int k = 0; k < DEP; k++)
            if (words[b_off[i] + k] !== exp_words[DEP * j + k]) d++;
        return d;
    endfunction

    task automatic push_word(input logic [DW-1:0] d, input logic sof,
                             input logic rate, input int pct);
        int w = 0;
        while ($urandom_range(0, 99) >= pct) begin
            in_if.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        in_if.in_sof   = sof;
        in_if.in_rate  = rate;
        forever begin
            @(negedge clk);
            if (in_if.in_ready) break;
            w++;
            if (w > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL push_timeout: in_ready stuck 0 for %0d cycles, required 1", w);
                break;
            end
        end
        @(posedge clk); #1;
        in_if.in_valid = 1'b0;
        in_if.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input logic rate, input int pct);
        for (int k = 0; k < DEP; k++) push_word(f[k], k == 0, rate, pct);
    endtask

    task automatic rand_frame(output frame_t f);
        for (int k = 0; k < DEP; k++) f[k] = DW'($urandom());
    endtask

    task automatic wait_bursts(input int n, input int bound, output bit ok);
        int k = 0;
        while (b_len.size() < n && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        ok = (b_len.size() >= n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        in_if.in_valid = 1'b0; in_if.in_sof = 1'b0;
        in_if.in_rate = 1'b0;  in_if.in_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b required 0", in_if.in_ready); end
        n_checks++; if (dec_sync !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %0b required 0", dec_sync); end
        n_checks++; if (dec_data !== '0) begin n_fail++; $display("FAIL rst_data: got %0d required 0", dec_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", frame_cnt); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b required 0", frame_err); end
        n_checks++; if (dec_code_rate !== 1'b0 || dec_max_iter !== 5'd0) begin n_fail++; $display("FAIL rst_cfg: got rate %0b iter %0d required 0 0", dec_code_rate, dec_max_iter); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %0b required 1", in_if.in_ready); end
        clear_mon();
    endtask

    task automatic test_single;
        frame_t f;
        bit ok;
        int mism = 0;
        clear_mon();
        dec_busy = 1'b0; cfg_max_iter = 5'd20;
        for (int k = 0; k < DEP; k++) f[k] = DW'(k);
        send_frame(f, 1'b1, 100);
        wait_bursts(1, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_burst: got 0 bursts required 1"); end
        if (ok) begin
            for (int k = 0; k < b_len[0] && k < DEP; k++) if (words[b_off[0] + k] !== DW'(k)) mism++;
            n_checks++; if (b_len[0] != DEP) begin n_fail++; $display("FAIL single_len: got %0d required %0d", b_len[0], DEP); end
            n_checks++; if (mism != 0) begin n_fail++; $display("FAIL single_data: got %0d wrong words required 0", mism); end
            n_checks++; if (b_rate[0] !== 1'b1) begin n_fail++; $display("FAIL single_rate: got %0b required 1", b_rate[0]); end
            n_checks++; if (b_iter[0] !== 5'd20) begin n_fail++; $display("FAIL single_iter: got %0d required 20", b_iter[0]); end
            n_checks++; if (b_start[0] - last_acc != 3) begin n_fail++; $display("FAIL single_latency: got %0d required 3", b_start[0] - last_acc); end
        end
        exp_cnt = exp_cnt + 1;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL single_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL single_err: got %0d pulses required 0", err_cnt); end
    endtask

    task automatic test_back_to_back;
        frame_t fa, fb, fc;
        bit ok;
        clear_mon();
        dec_busy = 1'b1; cfg_max_iter = 5'd7;
        rand_frame(fa); rand_frame(fb); rand_frame(fc);
        send_frame(fa, 1'b0, 100);
        send_frame(fb, 1'b1, 100);
        n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: in_ready got %0b required 0", in_if.in_ready); end
        fork
            send_frame(fc, 1'b0, 100);
            begin
                repeat (30) @(posedge clk); #1;
                n_checks++; if (b_start.size() != 0) begin n_fail++; $display("FAIL b2b_busy_hold: got %0d bursts required 0", b_start.size()); end
                dec_busy = 1'b0;
            end
        join
        wait_bursts(3, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_bursts: got %0d bursts required 3", b_len.size()); end
        n_checks++; if (exp_words.size() != 3 * DEP) begin n_fail++; $display("FAIL b2b_loss: got %0d words accepted required %0d", exp_words.size(), 3 * DEP); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (burst_diff(i, i) != 0) begin n_fail++; $display("FAIL b2b_data%0d: got %0d diffs required 0", i, burst_diff(i, i)); end
                n_checks++; if (b_rate[i] !== exp_rate[i]) begin n_fail++; $display("FAIL b2b_rate%0d: got %0b required %0b", i, b_rate[i], exp_rate[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (b_start[i + 1] - b_end[i] != 1) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d low cycles required 1", i, b_start[i + 1] - b_end[i]); end
            end
        end
        exp_cnt = exp_cnt + 3;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_busy_mid;
        frame_t f1, f2;
        bit ok;
        int rel;
        clear_mon();
        dec_busy = 1'b0; cfg_max_iter = 5'd11;
        rand_frame(f1); rand_frame(f2);
        fork
            begin
                send_frame(f1, 1'b1, 100);
                send_frame(f2, 1'b0, 100);
            end
            begin
                int k = 0;
                while (b_start.size() == 0 && k < 200) begin @(negedge clk); #1; k++; end
                repeat (4) @(negedge clk);
                dec_busy = 1'b1;
            end
        join
        wait_bursts(1, 100, ok);
        n_checks++; if (!ok || b_len[0] != DEP) begin n_fail++; $display("FAIL busy_len: got %0d bursts required a %0d-word burst", b_len.size(), DEP); end
        n_checks++; if (burst_diff(0, 0) != 0) begin n_fail++; $display("FAIL busy_data0: got %0d diffs required 0", burst_diff(0, 0)); end
        repeat (20) @(posedge clk); #1;
        n_checks++; if (b_start.size() != 1) begin n_fail++; $display("FAIL busy_hold: got %0d bursts required 1", b_start.size()); end
        rel = cyc;
        dec_busy = 1'b0;
        wait_bursts(2, 100, ok);
        n_checks++; if (!ok || b_start[1] <= rel) begin n_fail++; $display("FAIL busy_restart: got %0d bursts required 2 after release", b_len.size()); end
        n_checks++; if (burst_diff(1, 1) != 0) begin n_fail++; $display("FAIL busy_data1: got %0d diffs required 0", burst_diff(1, 1)); end
        exp_cnt = exp_cnt + 2;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL busy_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_sof_mid;
        frame_t f;
        bit ok;
        clear_mon();
        dec_busy = 1'b0; cfg_max_iter = 5'd3;
        for (int k = 0; k < 7; k++) push_word(DW'($urandom()), k == 0, 1'b0, 100);
        rand_frame(f);
        send_frame(f, 1'b1, 100);
        wait_bursts(1, 60, ok);
        repeat (20) @(posedge clk); #1;
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL sof_err: got %0d pulse cycles required 1", err_cnt); end
        n_checks++; if (b_len.size() != 1) begin n_fail++; $display("FAIL sof_bursts: got %0d required 1", b_len.size()); end
        n_checks++; if (burst_diff(0, 0) != 0) begin n_fail++; $display("FAIL sof_data: got %0d diffs required 0", burst_diff(0, 0)); end
        n_checks++; if (ok && b_rate[0] !== 1'b1) begin n_fail++; $display("FAIL sof_rate: got %0b required 1", b_rate[0]); end
        exp_cnt = exp_cnt + 1;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sof_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_random;
        frame_t f;
        bit ok;
        logic [4:0] it;
        clear_mon();
        dec_busy = 1'b0;
        it = 5'($urandom());
        cfg_max_iter = it;
        for (int n = 0; n < 4; n++) begin
            rand_frame(f);
            send_frame(f, n[0], 50);
        end
        wait_bursts(4, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_bursts: got %0d required 4", b_len.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (burst_diff(i, i) != 0) begin n_fail++; $display("FAIL rnd_data%0d: got %0d diffs required 0", i, burst_diff(i, i)); end
                n_checks++; if (b_rate[i] !== i[0]) begin n_fail++; $display("FAIL rnd_rate%0d: got %0b required %0b", i, b_rate[i], i[0]); end
                n_checks++; if (b_iter[i] !== it) begin n_fail++; $display("FAIL rnd_iter%0d: got %0d required %0d", i, b_iter[i], it); end
            end
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL rnd_stable: got %0d cfg changes required 0", unstable); end
        n_checks++; if (data_low != 0) begin n_fail++; $display("FAIL rnd_idle_data: got %0d nonzero idle words required 0", data_low); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rnd_err: got %0d pulses required 0", err_cnt); end
        exp_cnt = exp_cnt + 4;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rnd_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        frame_t f1, f2, f3;
        bit ok;
        int k = 0;
        clear_mon();
        dec_busy = 1'b1; cfg_max_iter = 5'd9;
        rand_frame(f1); rand_frame(f2); rand_frame(f3);
        send_frame(f1, 1'b1, 100);
        send_frame(f2, 1'b1, 100);
        dec_busy = 1'b0;
        while (b_start.size() == 0 && k < 50) begin @(negedge clk); #1; k++; end
        n_checks++; if (b_start.size() == 0) begin n_fail++; $display("FAIL rmid_start: got 0 bursts required 1"); end
        repeat (4) @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++; if (dec_sync !== 1'b0) begin n_fail++; $display("FAIL rmid_sync_drop: got %0b required 0", dec_sync); end
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (dec_sync !== 1'b0 || dec_data !== '0) begin n_fail++; $display("FAIL rmid_out: got sync %0b data %0d required 0 0", dec_sync, dec_data); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt0: got %0d required 0", frame_cnt); end
        n_checks++; if (dec_code_rate !== 1'b0 || dec_max_iter !== 5'd0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_cfg: got rate %0b iter %0d err %0b required 0 0 0", dec_code_rate, dec_max_iter, frame_err); end
        n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b required 1", in_if.in_ready); end
        @(posedge clk); #1;
        clear_mon();
        exp_cnt = 0;
        for (int j = 0; j < 3; j++) push_word(DW'($urandom()), 1'b0, 1'b0, 100);
        repeat (40) @(posedge clk); #1;
        n_checks++; if (b_start.size() != 0) begin n_fail++; $display("FAIL rmid_noburst: got %0d bursts required 0", b_start.size()); end
        send_frame(f3, 1'b0, 100);
        wait_bursts(1, 60, ok);
        n_checks++; if (burst_diff(0, 0) != 0) begin n_fail++; $display("FAIL rmid_data: got %0d diffs required 0", burst_diff(0, 0)); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rmid_err: got %0d pulses required 0", err_cnt); end
        exp_cnt = exp_cnt + 1;
        n_checks++; if (frame_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rmid_cnt: got %0d required %0d", frame_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_mid();
        test_sof_mid();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
